// File: rtl/systolic_skew_feeder.sv
// Input stage of an NxN output-stationary systolic array: skews A columns / B rows
// onto the west/north edges, drives the shared PE enable, flushes, then pulses done.
module systolic_skew_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 4,
  parameter int unsigned K_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [K_WIDTH-1:0]      k_len,
  output logic                    busy,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  output logic [N*DATA_WIDTH-1:0] edge_a,
  output logic [N*DATA_WIDTH-1:0] edge_b,
  output logic                    pe_enable,
  output logic                    done
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned FC_W = $clog2(2 * N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [K_WIDTH-1:0]  k_len_q, k_len_d;
  logic [K_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [FC_W-1:0]     flush_cnt_q, flush_cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                pe_enable_q, pe_enable_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign pe_enable = pe_enable_q;
  assign done      = done_q;

  // Next state; outputs are decoded from the next state so they register in step with it.
  // The flush lasts until the last beat has been accumulated at PE(N-1,N-1) one cycle ago.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (start && (k_len != '0)) begin
          state_d    = STREAM;
          k_len_d    = k_len;
          beat_cnt_d = '0;
        end
      end
      STREAM: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
          if (beat_cnt_q == (k_len_q - K_WIDTH'(1))) begin
            state_d     = FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + FC_W'(1);
        if (flush_cnt_q == FC_W'(2 * N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == STREAM);
    busy_d      = (state_d != IDLE);
    pe_enable_d = (state_d == STREAM) || (state_d == FLUSH);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      pe_enable_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      pe_enable_q <= pe_enable_d;
      done_q      <= done_d;
    end
  end

  // Lane i delays by i+1 registers; unaccepted slots shift in zeros so skew is preserved.
  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    logic [DW-1:0] a_d [i+1];
    logic [DW-1:0] a_q [i+1];
    logic [DW-1:0] b_d [i+1];
    logic [DW-1:0] b_q [i+1];

    always_comb begin
      a_d[0] = accept ? in_a[i*DW +: DW] : '0;
      b_d[0] = accept ? in_b[i*DW +: DW] : '0;
      for (int s = 1; s < i + 1; s++) begin
        a_d[s] = a_q[s-1];
        b_d[s] = b_q[s-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q <= '{default: '0};
        b_q <= '{default: '0};
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end

    assign edge_a[i*DW +: DW] = a_q[i];
    assign edge_b[i*DW +: DW] = b_q[i];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench: the feeder drives a behavioural 4x4 PE array; each job's A*B is
// queued at issue and compared at done, and every edge lane is checked against beat history.
module tb_systolic_skew_feeder;

  localparam int DW   = 16;
  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int KMAX = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [KW-1:0] k_len;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_a, in_b, edge_a, edge_b;
  logic          pe_enable;
  logic          done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .edge_a(edge_a), .edge_b(edge_b), .pe_enable(pe_enable), .done(done)
  );

  typedef struct {
    longint c [N][N];
  } job_t;

  job_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = -1;
  int   jobs_done = 0;
  bit   expect_idle = 1'b1;
  logic [N*DW-1:0] hist_a[int];
  logic [N*DW-1:0] hist_b[int];
  longint          acc [N][N];
  logic [DW-1:0]   pa [N][N];
  logic [DW-1:0]   pb [N][N];
  int              da [N][KMAX];
  int              db [KMAX][N];

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, req, cyc);
    end
  endfunction

  // Behavioural PE array fed from the DUT edges, plus a record of every accepted beat.
  always @(posedge clk) begin : b_harness
    logic [DW-1:0] av, bv;
    cyc++;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        av = (j == 0) ? edge_a[i*DW +: DW] : pa[i][j-1];
        bv = (i == 0) ? edge_b[j*DW +: DW] : pb[i-1][j];
        if (pe_enable) acc[i][j] += longint'($signed(av)) * longint'($signed(bv));
      end
    for (int i = N - 1; i >= 0; i--)
      for (int j = N - 1; j >= 0; j--) begin
        pa[i][j] = (j == 0) ? edge_a[i*DW +: DW] : pa[i][j-1];
        pb[i][j] = (i == 0) ? edge_b[j*DW +: DW] : pb[i-1][j];
      end
    if (reset) begin
      hist_a.delete();
      hist_b.delete();
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = 0;
          pa[i][j]  = '0;
          pb[i][j]  = '0;
        end
    end else begin
      if (start && !busy && (k_len != '0))
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) acc[i][j] = 0;
      if (in_valid && in_ready) begin
        hist_a[cyc] = in_a;
        hist_b[cyc] = in_b;
        last_acc    = cyc;
      end
    end
  end

  // Monitor: edge lanes every cycle, job results whenever done is presented.
  int idle_wait = 0;
  int busy_run = 0;
  bit busy_drop_chk = 1'b0;
  always @(negedge clk) begin : b_monitor
    logic [N*DW-1:0] ea, eb, ta, tb;
    job_t jb;
    if (reset) begin
      exp_q.delete();
      check("reset_edge_a", 64'(edge_a), 64'(0));
      check("reset_edge_b", 64'(edge_b), 64'(0));
      check("reset_ctrl", 64'({busy, in_ready, pe_enable, done}), 64'(0));
    end else begin
      ea = '0;
      eb = '0;
      for (int i = 0; i < N; i++) begin
        if (hist_a.exists(cyc - i)) begin
          ta = hist_a[cyc - i];
          tb = hist_b[cyc - i];
          ea[i*DW +: DW] = ta[i*DW +: DW];
          eb[i*DW +: DW] = tb[i*DW +: DW];
        end
      end
      check("edge_a", 64'(edge_a), 64'(ea));
      check("edge_b", 64'(edge_b), 64'(eb));
      if (expect_idle)
        check("idle_ctrl", 64'({busy, in_ready, pe_enable, done}), 64'(0));
      if (busy_drop_chk) begin
        check("busy_after_done", 64'(busy), 64'(0));
        busy_drop_chk = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 64'(done), 64'(0));
        end else begin
          jb = exp_q.pop_front();
          check("done_time", 64'(cyc), 64'(last_acc + 2 * N));
          check("done_ctrl", 64'({busy, pe_enable, in_ready}), 64'(3'b100));
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check("accum", 64'(acc[i][j]), 64'(jb.c[i][j]));
          jobs_done++;
          busy_drop_chk = 1'b1;
        end
      end
      idle_wait = (exp_q.size() > 0 && !busy) ? idle_wait + 1 : 0;
      if (idle_wait == 4) begin
        check("start_accepted", 64'(busy), 64'(1));
        void'(exp_q.pop_front());
      end
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run == 600) check("busy_bounded", 64'(busy), 64'(0));
    end
  end

  function automatic logic [N*DW-1:0] pack_a(int b);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(da[i][b]);
    return r;
  endfunction

  function automatic logic [N*DW-1:0] pack_b(int b);
    logic [N*DW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(db[b][j]);
    return r;
  endfunction

  // mode 0: back-to-back, 1: alternate bubbles, 2: random bubbles
  task automatic run_job(input int k, input int mode, input bit rst_after2, input bit start_mid);
    job_t jb;
    int   b = 0;
    int   guard = 0;
    int   jd0;
    bit   v;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        jb.c[i][j] = 0;
        for (int kk = 0; kk < k; kk++) jb.c[i][j] += longint'(da[i][kk]) * longint'(db[kk][j]);
      end
    jd0 = jobs_done;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    exp_q.push_back(jb);
    @(negedge clk);
    start = 1'b0;
    while (b < k && guard < 500) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = guard[0];
        default: v = ($urandom_range(0, 9) < 6);
      endcase
      start = start_mid && (b == 2);
      if (start) k_len = KW'(7);
      if (in_ready && v) begin
        in_valid = 1'b1;
        in_a = pack_a(b);
        in_b = pack_b(b);
        b++;
      end else begin
        in_valid = 1'b0;
        in_a = {$urandom, $urandom};
        in_b = {$urandom, $urandom};
      end
      @(negedge clk);
      guard++;
      if (rst_after2 && b == 2) begin
        in_valid = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    for (int t = 0; t < 300 && jobs_done == jd0; t++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_identity_b16();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        da[i][kk] = (i == kk) ? 1 : 0;
        db[i][kk] = i * N + kk + 1;
      end
  endtask

  task automatic load_random(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        da[i][kk] = int'($urandom_range(0, 65535)) - 32768;
        db[kk][i] = int'($urandom_range(0, 65535)) - 32768;
      end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    k_len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    expect_idle = 1'b0;

    // single beat, lanes 3..0 = 4,3,2,1
    for (int i = 0; i < N; i++) begin
      da[i][0] = i + 1;
      db[0][i] = int'($urandom_range(0, 200)) - 100;
    end
    run_job(1, 0, 1'b0, 1'b0);

    load_identity_b16();
    run_job(4, 0, 1'b0, 1'b0);
    run_job(4, 1, 1'b0, 1'b0);

    // zero-length start is ignored
    @(negedge clk);
    expect_idle = 1'b1;
    start = 1'b1;
    k_len = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    expect_idle = 1'b0;

    // start during STREAM is ignored
    load_random(4);
    run_job(4, 0, 1'b0, 1'b1);

    // reset after two beats abandons the job, then a fresh identity job
    load_identity_b16();
    run_job(4, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    run_job(4, 0, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      int k;
      k = int'($urandom_range(1, KMAX));
      load_random(k);
      run_job(k, 2, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
